// File: rtl/instr_encoder.sv
// Program loader: packs instruction field bundles into ARM words
// and writes them to consecutive words of instruction/data memory.
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [1:0]  in_cmd,
    input  logic        in_s,
    input  logic        in_i,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [23:0] in_src,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic [15:0] count,
    output logic        done,
    output logic        full,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, ENC, WRITE, DONE, FULL
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t      state, state_nx;
    logic [1:0]  kind_q, cmd_q;
    logic        s_q, i_q, last_q;
    logic [3:0]  cond_q, rn_q, rd_q;
    logic [23:0] src_q;
    logic [31:0] word, wd_q;
    logic [15:0] cnt_q;
    logic        err_q;
    logic        accept, illegal, at_limit, may_start;
    logic [3:0]  cmdcode;

    assign accept    = in_valid & in_ready;
    assign illegal   = kind_q == 2'b11;
    assign at_limit  = (cnt_q + 16'd1) == DEPTH_W;
    assign may_start = start & (state == IDLE || state == DONE
                                || state == FULL);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept) state_nx = ENC;
            ENC:   begin
                if (!illegal)    state_nx = WRITE;
                else if (last_q) state_nx = DONE;
                else             state_nx = IDLE;
            end
            WRITE: begin
                if (last_q)        state_nx = DONE;
                else if (at_limit) state_nx = FULL;
                else               state_nx = IDLE;
            end
            DONE, FULL: if (start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) & ~start & ~reset;
        mem_we   = state == WRITE;
        done     = state == DONE;
    end

    always_comb begin
        cmdcode = 4'b0100;
        unique case (cmd_q)
            2'b00: cmdcode = 4'b0100;
            2'b01: cmdcode = 4'b0010;
            2'b10: cmdcode = 4'b0000;
            2'b11: cmdcode = 4'b1100;
            default: cmdcode = 4'b0100;
        endcase
    end

    // P=1 U=1 B=0 W=0 for memory ops; I is inverted in the encoding
    always_comb begin
        word = '0;
        unique case (kind_q)
            2'b00: word = {cond_q, 2'b00, i_q, cmdcode, s_q,
                           rn_q, rd_q, src_q[11:0]};
            2'b01: word = {cond_q, 2'b01, ~i_q, 4'b1100, s_q,
                           rn_q, rd_q, src_q[11:0]};
            2'b10: word = {cond_q, 2'b10, 2'b10, src_q};
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q <= '0;
            cmd_q  <= '0;
            s_q    <= 1'b0;
            i_q    <= 1'b0;
            last_q <= 1'b0;
            cond_q <= '0;
            rn_q   <= '0;
            rd_q   <= '0;
            src_q  <= '0;
            wd_q   <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                kind_q <= in_kind;
                cmd_q  <= in_cmd;
                s_q    <= in_s;
                i_q    <= in_i;
                last_q <= in_last;
                cond_q <= in_cond;
                rn_q   <= in_rn;
                rd_q   <= in_rd;
                src_q  <= in_src;
            end
            if (state == ENC && !illegal) wd_q <= word;
            if (state == ENC && illegal)  err_q <= 1'b1;
            if (state == WRITE) cnt_q <= cnt_q + 16'd1;
            if (may_start) begin
                cnt_q <= '0;
                err_q <= 1'b0;
            end
        end
    end

    assign mem_addr = BASE_ADDR + {14'b0, cnt_q, 2'b00};
    assign mem_wd   = wd_q;
    assign count    = cnt_q;
    assign full     = cnt_q == DEPTH_W;
    assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, random programs
// against a field-level encoding model, full/done/reset corners.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h100;
    localparam int          DEPTH = 8;

    typedef struct {
        logic [1:0]  kind;
        logic [1:0]  cmd;
        logic        s;
        logic        i;
        logic [3:0]  cond;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [23:0] src;
        logic        last;
    } bnd_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [1:0]  in_kind = 0;
    logic [1:0]  in_cmd = 0;
    logic        in_s = 0;
    logic        in_i = 0;
    logic [3:0]  in_cond = 0;
    logic [3:0]  in_rn = 0;
    logic [3:0]  in_rd = 0;
    logic [23:0] in_src = 0;
    logic        in_last = 0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [15:0] count;
    logic        done;
    logic        full;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_cmd(in_cmd), .in_s(in_s),
        .in_i(in_i), .in_cond(in_cond), .in_rn(in_rn),
        .in_rd(in_rd), .in_src(in_src), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .count(count), .done(done), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we === 1'b1) wr_cnt <= wr_cnt + 1;

    function automatic bnd_t mk(logic [1:0] kind, logic [1:0] cmd,
                                logic s, logic i, logic [3:0] cond,
                                logic [3:0] rn, logic [3:0] rd,
                                logic [23:0] src, logic last);
        bnd_t b;
        b.kind = kind; b.cmd = cmd; b.s = s; b.i = i;
        b.cond = cond; b.rn = rn; b.rd = rd; b.src = src;
        b.last = last;
        return b;
    endfunction

    function automatic bnd_t rnd_bundle(bit legal, logic last);
        bnd_t b;
        b.kind = legal ? 2'($urandom_range(0, 2)) : 2'b11;
        b.cmd  = 2'($urandom);
        b.s    = 1'($urandom);
        b.i    = 1'($urandom);
        b.cond = 4'($urandom);
        b.rn   = 4'($urandom);
        b.rd   = 4'($urandom);
        b.src  = 24'($urandom);
        b.last = last;
        return b;
    endfunction

    // Reference encoding built from field positions with shifts
    function automatic logic [31:0] model_word(bnd_t b);
        logic [3:0]  codes [4];
        logic [31:0] w;
        codes = '{4'h4, 4'h2, 4'h0, 4'hC};
        w = 32'(b.cond) << 28;
        if (b.kind == 2'd0)
            w = w | (32'(b.i) << 25) | (32'(codes[b.cmd]) << 21)
                  | (32'(b.s) << 20) | (32'(b.rn) << 16)
                  | (32'(b.rd) << 12) | (32'(b.src) & 32'hFFF);
        else if (b.kind == 2'd1)
            w = w | (32'd1 << 26) | (32'(!b.i) << 25)
                  | (32'd3 << 23) | (32'(b.s) << 20)
                  | (32'(b.rn) << 16) | (32'(b.rd) << 12)
                  | (32'(b.src) & 32'hFFF);
        else
            w = w | (32'hA << 24) | (32'(b.src) & 32'hFFFFFF);
        return w;
    endfunction

    // Returns at the falling edge after the accepting edge
    task automatic offer(input bnd_t b, output bit acc);
        int n;
        @(negedge clk);
        in_kind = b.kind; in_cmd = b.cmd; in_s = b.s; in_i = b.i;
        in_cond = b.cond; in_rn = b.rn; in_rd = b.rd;
        in_src = b.src; in_last = b.last;
        in_valid = 1;
        n = 0;
        while (in_ready !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        acc = in_ready === 1'b1;
        if (acc) @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        in_last = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_ready_held got %b exp 0", in_ready);
        end
        reset = 0;
        #1;
        vectors++;
        if ({in_ready, mem_we, done, full, err} !== 5'b10000
            || mem_wd !== 32'h0 || mem_addr !== BASE
            || count !== 16'd0) begin
            miscompares++;
            $display("FAIL rst_vals got rdy%b we%b d%b f%b e%b wd%h a%h c%0d",
                     in_ready, mem_we, done, full, err,
                     mem_wd, mem_addr, count);
        end
    endtask

    task automatic test_directed();
        bnd_t        tb_[4];
        logic [31:0] ew [4];
        int          off [4];
        bit          acc;
        tb_[0] = mk(2'd0, 2'd0, 0, 1, 4'hE, 4'd2, 4'd1, 24'h5, 0);
        tb_[1] = mk(2'd0, 2'd1, 1, 0, 4'hE, 4'd3, 4'd3, 24'h4, 0);
        tb_[2] = mk(2'd1, 2'd0, 1, 1, 4'hE, 4'd1, 4'd0, 24'h8, 0);
        tb_[3] = mk(2'd1, 2'd0, 0, 1, 4'hE, 4'd1, 4'd0, 24'h8, 0);
        ew = '{32'hE2821005, 32'hE0533004, 32'hE5910008, 32'hE5810008};
        off = '{0, 0, 4, 8};
        for (int k = 0; k < 4; k++) begin
            if (k == 1) pulse_start();
            offer(tb_[k], acc);
            vectors++;
            if (!acc || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_enc acc %b we %b exp 1/0",
                         k, acc, mem_we);
            end
            @(negedge clk);
            vectors++;
            if (mem_we !== 1'b1 || mem_wd !== ew[k]
                || mem_addr !== BASE + 32'(off[k])) begin
                miscompares++;
                $display("FAIL dir%0d_wr got we%b %h@%h exp %h@%h",
                         k, mem_we, mem_wd, mem_addr,
                         ew[k], BASE + 32'(off[k]));
            end
            @(negedge clk);
            vectors++;
            if (count !== 16'(off[k] / 4 + 1) || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL dir%0d_cnt got %0d exp %0d",
                         k, count, off[k] / 4 + 1);
            end
        end
    endtask

    task automatic test_branch_last();
        bit acc;
        pulse_start();
        offer(mk(2'd2, 2'd3, 1, 1, 4'hE, 4'd7, 4'd9, 24'hFFFFFE, 1),
              acc);
        @(negedge clk);
        vectors++;
        if (!acc || mem_we !== 1'b1 || mem_wd !== 32'hEAFFFFFE
            || mem_addr !== BASE) begin
            miscompares++;
            $display("FAIL br_wr got we%b %h@%h exp EAFFFFFE@%h",
                     mem_we, mem_wd, mem_addr, BASE);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || in_ready !== 1'b0 || count !== 16'd1) begin
            miscompares++;
            $display("FAIL br_done got d%b r%b c%0d exp 1 0 1",
                     done, in_ready, count);
        end
        offer(rnd_bundle(1, 0), acc);
        vectors++;
        if (acc || done !== 1'b1 || wr_cnt === 0) begin
            miscompares++;
            $display("FAIL br_hold got acc%b done%b exp 0 1", acc, done);
        end
        pulse_start();
        vectors++;
        if (done !== 1'b0 || count !== 16'd0 || mem_addr !== BASE
            || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL br_start got d%b c%0d a%h r%b",
                     done, count, mem_addr, in_ready);
        end
    endtask

    task automatic test_illegal();
        bit acc;
        int w0;
        bnd_t b;
        pulse_start();
        w0 = wr_cnt;
        offer(rnd_bundle(0, 0), acc);
        @(negedge clk);
        vectors++;
        if (!acc || mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL ill_nowe got acc%b we%b exp 1 0", acc, mem_we);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || count !== 16'd0 || wr_cnt !== w0) begin
            miscompares++;
            $display("FAIL ill_err got e%b c%0d w%0d exp 1 0 %0d",
                     err, count, wr_cnt, w0);
        end
        b = rnd_bundle(1, 0);
        offer(b, acc);
        @(negedge clk);
        vectors++;
        if (mem_we !== 1'b1 || mem_wd !== model_word(b)
            || mem_addr !== BASE || err !== 1'b1) begin
            miscompares++;
            $display("FAIL ill_next got %h@%h e%b exp %h@%h",
                     mem_wd, mem_addr, err, model_word(b), BASE);
        end
        pulse_start();
        vectors++;
        if (err !== 1'b0 || count !== 16'd0) begin
            miscompares++;
            $display("FAIL ill_clr got e%b c%0d exp 0 0", err, count);
        end
    endtask

    task automatic test_random();
        bit   acc, legal;
        bnd_t b;
        int   n, ecnt, ewr, w0;
        logic eerr;
        for (int p = 0; p < 8; p++) begin
            pulse_start();
            w0 = wr_cnt;
            ewr = 0;
            ecnt = 0;
            eerr = 0;
            n = $urandom_range(2, 7);
            for (int k = 0; k < n; k++) begin
                legal = $urandom_range(0, 4) != 0;
                b = rnd_bundle(legal, k == n - 1);
                offer(b, acc);
                @(negedge clk);
                vectors++;
                if (!acc || mem_we !== legal || (legal
                    && (mem_wd !== model_word(b)
                    || mem_addr !== BASE + 32'(4 * ecnt)))) begin
                    miscompares++;
                    $display("FAIL rnd_wr p%0d k%0d got acc%b we%b %h@%h exp %b %h@%h",
                             p, k, acc, mem_we, mem_wd, mem_addr,
                             legal, model_word(b), BASE + 32'(4 * ecnt));
                end
                if (legal) begin
                    ecnt++;
                    ewr++;
                end else begin
                    eerr = 1;
                end
                @(negedge clk);
                vectors++;
                if (count !== 16'(ecnt) || err !== eerr
                    || done !== (k == n - 1)) begin
                    miscompares++;
                    $display("FAIL rnd_st p%0d k%0d got c%0d e%b d%b exp %0d %b %b",
                             p, k, count, err, done, ecnt, eerr, k == n - 1);
                end
            end
            vectors++;
            if (wr_cnt - w0 !== ewr || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_total p%0d got %0d exp %0d",
                         p, wr_cnt - w0, ewr);
            end
        end
    endtask

    task automatic test_full();
        bit   acc;
        bnd_t b;
        int   w0;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            for (int k = 0; k < DEPTH; k++) begin
                b = rnd_bundle(1, r == 1 && k == DEPTH - 1);
                offer(b, acc);
                @(negedge clk);
                vectors++;
                if (!acc || mem_wd !== model_word(b)
                    || mem_addr !== BASE + 32'(4 * k)) begin
                    miscompares++;
                    $display("FAIL full_wr r%0d k%0d got %h@%h exp %h@%h",
                             r, k, mem_wd, mem_addr, model_word(b),
                             BASE + 32'(4 * k));
                end
                @(negedge clk);
            end
            vectors++;
            if (full !== 1'b1 || done !== (r == 1)
                || count !== 16'(DEPTH) || in_ready !== 1'b0
                || mem_addr !== BASE + 32'(4 * DEPTH)) begin
                miscompares++;
                $display("FAIL full_flag r%0d got f%b d%b c%0d r%b a%h",
                         r, full, done, count, in_ready, mem_addr);
            end
            w0 = wr_cnt;
            offer(rnd_bundle(1, 0), acc);
            vectors++;
            if (acc || wr_cnt !== w0) begin
                miscompares++;
                $display("FAIL full_block r%0d got acc%b w%0d exp 0 %0d",
                         r, acc, wr_cnt, w0);
            end
            pulse_start();
            vectors++;
            if (count !== 16'd0 || full !== 1'b0 || done !== 1'b0
                || mem_addr !== BASE || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL full_start r%0d got c%0d f%b d%b a%h",
                         r, count, full, done, mem_addr);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int w0;
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            offer(rnd_bundle(1, 0), acc);
            if (r == 1) @(negedge clk);
            reset = 1;
            @(negedge clk);
            w0 = wr_cnt;
            vectors++;
            if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL mid%0d_we got we%b r%b exp 0 0",
                         r, mem_we, in_ready);
            end
            reset = 0;
            #1;
            vectors++;
            if ({in_ready, mem_we, done, full, err} !== 5'b10000
                || mem_wd !== 32'h0 || mem_addr !== BASE
                || count !== 16'd0) begin
                miscompares++;
                $display("FAIL mid%0d_vals got r%b we%b wd%h a%h c%0d",
                         r, in_ready, mem_we, mem_wd, mem_addr, count);
            end
            repeat (3) @(negedge clk);
            vectors++;
            if (wr_cnt !== w0) begin
                miscompares++;
                $display("FAIL mid%0d_late got %0d writes exp %0d",
                         r, wr_cnt, w0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_branch_last();
        test_illegal();
        test_random();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
